// File: rtl/mandel_pixel_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mandel_pixel_engine: fixed-point Mandelbrot iterator, one point at a time. |
// | Optional MANDEL_PIPE_MUL_EN registers the squares (MUL -> EVAL per step).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mandel_pixel_engine #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 28,
  parameter int MAX_ITER  = 64,
  parameter int ITER_W    = 8,
  parameter int ADDR_W    = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  cx,
  input  logic [WIDTH-1:0]  cy,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              busy,
  output logic              done,
  output logic              in_set,
  output logic [ITER_W-1:0] iter_out,
  output logic [ADDR_W-1:0] addr_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

  localparam logic signed [WIDTH-1:0] c_two =
    {{(WIDTH-FRAC_BITS-2){1'b0}}, 2'b10, {FRAC_BITS{1'b0}}};
  localparam logic signed [WIDTH-1:0] c_neg_two = -c_two;
  localparam logic signed [WIDTH:0]   c_four =
    {{(WIDTH-FRAC_BITS-2){1'b0}}, 3'b100, {FRAC_BITS{1'b0}}};
  localparam logic [ITER_W-1:0]       c_max_iter = ITER_W'(MAX_ITER);

  // Q-format multiply: full 2W-bit signed product, rescaled back to W bits.
  function automatic logic signed [WIDTH-1:0] fx_mul(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [2*WIDTH-1:0] p;
    p = a * b;
    return p[FRAC_BITS+WIDTH-1:FRAC_BITS];
  endfunction

  state_t                   state_q, state_d;
  logic signed [WIDTH-1:0]  zr_q, zr_d, zi_q, zi_d;
  logic signed [WIDTH-1:0]  cr_q, cr_d, ci_q, ci_d;
  logic [ITER_W-1:0]        n_q, n_d;
  logic [ADDR_W-1:0]        tag_q, tag_d;
  logic                     busy_q, busy_d, done_q, done_d, in_set_q, in_set_d;
  logic [ITER_W-1:0]        iter_q, iter_d;
  logic [ADDR_W-1:0]        addr_out_q, addr_out_d;

  logic signed [WIDTH-1:0]  ev_rr, ev_ii, ev_ri;
  logic signed [WIDTH:0]    mag_sum;
  logic                     escape;

`ifdef MANDEL_PIPE_MUL_EN
  logic signed [WIDTH-1:0]  rr_q, rr_d, ii_q, ii_d, ri_q, ri_d;
  assign ev_rr = rr_q;
  assign ev_ii = ii_q;
  assign ev_ri = ri_q;
`else
  assign ev_rr = fx_mul(zr_q, zr_q);
  assign ev_ii = fx_mul(zi_q, zi_q);
  assign ev_ri = fx_mul(zr_q, zi_q);
`endif

  // Squares are only trusted when |zr|,|zi| <= 2; the magnitude tests cover the rest.
  assign mag_sum = {ev_rr[WIDTH-1], ev_rr} + {ev_ii[WIDTH-1], ev_ii};
  assign escape  = (zr_q > c_two) || (zr_q < c_neg_two) ||
                   (zi_q > c_two) || (zi_q < c_neg_two) ||
                   (mag_sum > c_four);

  always_comb begin
    state_d    = state_q;
    zr_d       = zr_q;
    zi_d       = zi_q;
    cr_d       = cr_q;
    ci_d       = ci_q;
    n_d        = n_q;
    tag_d      = tag_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    in_set_d   = in_set_q;
    iter_d     = iter_q;
    addr_out_d = addr_out_q;
`ifdef MANDEL_PIPE_MUL_EN
    rr_d       = rr_q;
    ii_d       = ii_q;
    ri_d       = ri_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cr_d    = cx;
          ci_d    = cy;
          tag_d   = addr_in;
          zr_d    = '0;
          zi_d    = '0;
          n_d     = '0;
          busy_d  = 1'b1;
          state_d = ST_ITER;
`ifdef MANDEL_PIPE_MUL_EN
          // z starts at 0, so its products are known and the first MUL is skipped.
          rr_d    = '0;
          ii_d    = '0;
          ri_d    = '0;
`endif
        end
      end
      ST_ITER: begin
        if (escape) begin
          in_set_d   = 1'b0;
          iter_d     = n_q;
          addr_out_d = tag_q;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else if (n_q == c_max_iter) begin
          in_set_d   = 1'b1;
          iter_d     = c_max_iter;
          addr_out_d = tag_q;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          zr_d = ev_rr - ev_ii + cr_q;
          zi_d = (ev_ri <<< 1) + ci_q;
          n_d  = n_q + ITER_W'(1);
`ifdef MANDEL_PIPE_MUL_EN
          state_d = ST_MUL;
`endif
        end
      end
`ifdef MANDEL_PIPE_MUL_EN
      ST_MUL: begin
        rr_d    = fx_mul(zr_q, zr_q);
        ii_d    = fx_mul(zi_q, zi_q);
        ri_d    = fx_mul(zr_q, zi_q);
        state_d = ST_ITER;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      zr_q       <= '0;
      zi_q       <= '0;
      cr_q       <= '0;
      ci_q       <= '0;
      n_q        <= '0;
      tag_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_set_q   <= 1'b0;
      iter_q     <= '0;
      addr_out_q <= '0;
`ifdef MANDEL_PIPE_MUL_EN
      rr_q       <= '0;
      ii_q       <= '0;
      ri_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      zr_q       <= zr_d;
      zi_q       <= zi_d;
      cr_q       <= cr_d;
      ci_q       <= ci_d;
      n_q        <= n_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_set_q   <= in_set_d;
      iter_q     <= iter_d;
      addr_out_q <= addr_out_d;
`ifdef MANDEL_PIPE_MUL_EN
      rr_q       <= rr_d;
      ii_q       <= ii_d;
      ri_q       <= ri_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign in_set   = in_set_q;
  assign iter_out = iter_q;
  assign addr_out = addr_out_q;

endmodule
`default_nettype wire

// File: tb/tb_mandel_pixel_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mandel_pixel_engine: directed self-checking bench for the pixel engine. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mandel_pixel_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] cx;
  logic [31:0] cy;
  logic [18:0] addr_in;
  logic        busy;
  logic        done;
  logic        in_set;
  logic [7:0]  iter_out;
  logic [18:0] addr_out;

  int checks = 0;
  int errors = 0;

`ifdef MANDEL_PIPE_MUL_EN
  localparam int c_lat_inset = 130;
  localparam int c_lat_esc2  = 6;
`else
  localparam int c_lat_inset = 66;
  localparam int c_lat_esc2  = 4;
`endif
  localparam int c_limit = 200;

  localparam logic [31:0] c_one     = 32'h1000_0000;
  localparam logic [31:0] c_neg_two = 32'hE000_0000;

  mandel_pixel_engine dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cx       (cx),
    .cy       (cy),
    .addr_in  (addr_in),
    .busy     (busy),
    .done     (done),
    .in_set   (in_set),
    .iter_out (iter_out),
    .addr_out (addr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single clock edge; returns just after that edge.
  task automatic kick(input logic [31:0] r, input logic [31:0] i, input logic [18:0] a);
    @(negedge clk);
    cx      = r;
    cy      = i;
    addr_in = a;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Latency counts the start cycle as 0, so the first sample after the start edge is 1.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < c_limit) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bc;
    int pulses;

    rst     = 1'b1;
    start   = 1'b0;
    cx      = '0;
    cy      = '0;
    addr_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_in_set", 32'(in_set), 32'd0);
    check("rst_iter", 32'(iter_out), 32'd0);
    check("rst_addr", 32'(addr_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // c = 0: never escapes
    kick(32'h0, 32'h0, 19'h12345);
    wait_done(lat, bc);
    check("t1_latency", 32'(lat), 32'(c_lat_inset));
    check("t1_busy_cycles", 32'(bc), 32'(c_lat_inset - 1));
    check("t1_in_set", 32'(in_set), 32'd1);
    check("t1_iter", 32'(iter_out), 32'd64);
    check("t1_addr", 32'(addr_out), 32'h12345);
    @(posedge clk);
    #1;
    check("t1_done_one_cycle", 32'(done), 32'd0);
    check("t1_result_hold", 32'(iter_out), 32'd64);

    // c = 1+i: z1 = 1+i, z2 = 1+3i escapes at n = 2
    kick(c_one, c_one, 19'h0ABCD);
    wait_done(lat, bc);
    check("t2_latency", 32'(lat), 32'(c_lat_esc2));
    check("t2_in_set", 32'(in_set), 32'd0);
    check("t2_iter", 32'(iter_out), 32'd2);
    check("t2_addr", 32'(addr_out), 32'h0ABCD);

    // c = -2: z sits at exactly 2.0, strict compares keep it in-set
    kick(c_neg_two, 32'h0, 19'h7FFFF);
    wait_done(lat, bc);
    check("t3_latency", 32'(lat), 32'(c_lat_inset));
    check("t3_in_set", 32'(in_set), 32'd1);
    check("t3_iter", 32'(iter_out), 32'd64);
    check("t3_addr", 32'(addr_out), 32'h7FFFF);

    // Start while busy is ignored
    kick(c_one, c_one, 19'h00111);
    @(negedge clk);
    cx      = 32'h0;
    cy      = 32'h0;
    addr_in = 19'h00222;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bc);
    check("t4_first_done", 32'(done), 32'd1);
    check("t4_first_addr", 32'(addr_out), 32'h00111);
    check("t4_first_iter", 32'(iter_out), 32'd2);
    // Start issued in the done cycle is accepted
    kick(c_one, c_one, 19'h00333);
    check("t4_b2b_busy", 32'(busy), 32'd1);
    check("t4_b2b_done_low", 32'(done), 32'd0);
    wait_done(lat, bc);
    check("t4_b2b_latency", 32'(lat), 32'(c_lat_esc2));
    check("t4_b2b_addr", 32'(addr_out), 32'h00333);
    check("t4_b2b_iter", 32'(iter_out), 32'd2);

    // Asynchronous reset mid-iteration of c = 0
    kick(32'h0, 32'h0, 19'h04444);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int k = 0; k < 150; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    check("t5_no_done_after_rst", 32'(pulses), 32'd0);
    kick(c_one, c_one, 19'h05555);
    wait_done(lat, bc);
    check("t5_after_latency", 32'(lat), 32'(c_lat_esc2));
    check("t5_after_in_set", 32'(in_set), 32'd0);
    check("t5_after_iter", 32'(iter_out), 32'd2);
    check("t5_after_addr", 32'(addr_out), 32'h05555);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
